// File: rtl/hp48_bus_sequencer_pkg.sv
// Shared definitions for the hp48_bus request sequencer: bus command encodings,
// sequencer states and default geometry.
package hp48_bus_sequencer_pkg;

  localparam int SEQ_ADDR_W  = 20;
  localparam int SEQ_MAX_NIB = 16;

  typedef enum logic [3:0] {
    BUSCMD_NOP      = 4'h0,
    BUSCMD_LOAD_PC  = 4'h1,
    BUSCMD_LOAD_DP  = 4'h2,
    BUSCMD_PC_READ  = 4'h3,
    BUSCMD_DP_READ  = 4'h4,
    BUSCMD_DP_WRITE = 4'h5
  } bus_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/hp48_bus_sequencer_ptr_tracker.sv
// Mirror of one bus-side pointer (PC or DP): whether it is known, and which
// nibble address it will present next.
module hp48_bus_sequencer_ptr_tracker
  import hp48_bus_sequencer_pkg::*;
#(
  parameter int ADDR_W = SEQ_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic              i_incr,
  input  logic              i_inval,
  input  logic [ADDR_W-1:0] i_load_addr,
  output logic              o_ok,
  output logic [ADDR_W-1:0] o_next
);

  logic              r_ok;
  logic [ADDR_W-1:0] r_next;

  // NOTE: sequential state is written only with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ok   <= 1'b0;
      r_next <= '0;
    end else begin
      if (i_load) begin
        r_ok   <= 1'b1;
        r_next <= i_load_addr;
      end else if (i_incr) begin
        r_next <= r_next + ADDR_W'(1);
      end
      // An error leaves the real bus pointer position unknown; this wins over load/incr.
      if (i_inval) begin
        r_ok <= 1'b0;
      end
    end
  end

  assign o_ok   = r_ok;
  assign o_next = r_next;

endmodule

// File: rtl/hp48_bus_sequencer.sv
// Converts one CPU nibble request into the per-cycle LOAD / READ / WRITE command
// stream for hp48_bus, skipping LOAD when the tracked pointer already matches.
module hp48_bus_sequencer
  import hp48_bus_sequencer_pkg::*;
#(
  parameter int ADDR_W  = SEQ_ADDR_W,
  parameter int MAX_NIB = SEQ_MAX_NIB
) (
  input  logic                       i_strobe,
  input  logic                       i_reset,
  input  logic                       i_req_valid,
  output logic                       o_req_ready,
  input  logic                       i_req_write,
  input  logic                       i_req_use_dp,
  input  logic [ADDR_W-1:0]          i_req_address,
  input  logic [$clog2(MAX_NIB)-1:0] i_req_count,
  input  logic [4*MAX_NIB-1:0]       i_req_wdata,
  output logic                       o_rsp_valid,
  output logic                       o_rsp_error,
  output logic [4*MAX_NIB-1:0]       o_rsp_rdata,
  output logic [ADDR_W-1:0]          o_bus_address,
  output logic [3:0]                 o_bus_command,
  output logic [3:0]                 o_bus_nibble_out,
  input  logic [3:0]                 i_bus_nibble_in,
  input  logic                       i_bus_error
);

  localparam int CNT_W  = $clog2(MAX_NIB);
  localparam int DATA_W = 4 * MAX_NIB;

  seq_state_e        r_state, w_state_next;
  logic              r_write;
  logic              r_use_dp;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_nib_idx;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_error;

  logic              w_accept;
  logic              w_sel_dp;
  logic              w_hit;
  logic              w_last;
  logic              w_xfer;
  logic              w_pc_ok, w_dp_ok;
  logic [ADDR_W-1:0] w_pc_next, w_dp_next;
  logic [CNT_W+1:0]  w_bit_base;

  // There is no PC write command, so every write goes through DP.
  assign w_sel_dp   = i_req_use_dp | i_req_write;
  assign w_accept   = (r_state == ST_IDLE) && i_req_valid;
  assign w_hit      = w_sel_dp ? (w_dp_ok && (w_dp_next == i_req_address))
                               : (w_pc_ok && (w_pc_next == i_req_address));
  assign w_last     = (r_nib_idx == r_count);
  assign w_xfer     = (r_state == ST_XFER);
  assign w_bit_base = {r_nib_idx, 2'b00};

  always_ff @(posedge i_strobe) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (i_req_valid) w_state_next = w_hit ? ST_XFER : ST_LOAD;
      ST_LOAD: w_state_next = ST_XFER;
      ST_XFER: if (i_bus_error || w_last) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready      = 1'b0;
    o_rsp_valid      = 1'b0;
    o_bus_command    = BUSCMD_NOP;
    o_bus_address    = '0;
    o_bus_nibble_out = 4'h0;
    unique case (r_state)
      ST_IDLE: o_req_ready = 1'b1;
      ST_LOAD: begin
        o_bus_command = r_use_dp ? BUSCMD_LOAD_DP : BUSCMD_LOAD_PC;
        o_bus_address = r_addr;
      end
      ST_XFER: begin
        o_bus_address = r_addr + ADDR_W'(r_nib_idx);
        if (r_write) begin
          o_bus_command    = BUSCMD_DP_WRITE;
          o_bus_nibble_out = r_wdata[w_bit_base +: 4];
        end else begin
          o_bus_command = r_use_dp ? BUSCMD_DP_READ : BUSCMD_PC_READ;
        end
      end
      ST_DONE: o_rsp_valid = 1'b1;
      default: o_req_ready = 1'b0;
    endcase
  end

  // Request latch and read assembly; rdata/error persist until the next accept.
  always_ff @(posedge i_strobe) begin
    if (i_reset) begin
      r_write   <= 1'b0;
      r_use_dp  <= 1'b0;
      r_addr    <= '0;
      r_count   <= '0;
      r_nib_idx <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_error   <= 1'b0;
    end else if (w_accept) begin
      r_write   <= i_req_write;
      r_use_dp  <= w_sel_dp;
      r_addr    <= i_req_address;
      r_count   <= i_req_count;
      r_nib_idx <= '0;
      r_wdata   <= i_req_wdata;
      r_rdata   <= '0;
      r_error   <= 1'b0;
    end else if (w_xfer) begin
      if (!r_write) r_rdata[w_bit_base +: 4] <= i_bus_nibble_in;
      if (i_bus_error) r_error <= 1'b1;
      r_nib_idx <= r_nib_idx + CNT_W'(1);
    end
  end

  assign o_rsp_error = r_error;
  assign o_rsp_rdata = r_rdata;

  hp48_bus_sequencer_ptr_tracker #(.ADDR_W(ADDR_W)) u_pc_tracker (
    .i_clk       (i_strobe),
    .i_reset     (i_reset),
    .i_load      ((r_state == ST_LOAD) && !r_use_dp),
    .i_incr      (w_xfer && !r_use_dp),
    .i_inval     (w_xfer && !r_use_dp && i_bus_error),
    .i_load_addr (r_addr),
    .o_ok        (w_pc_ok),
    .o_next      (w_pc_next)
  );

  hp48_bus_sequencer_ptr_tracker #(.ADDR_W(ADDR_W)) u_dp_tracker (
    .i_clk       (i_strobe),
    .i_reset     (i_reset),
    .i_load      ((r_state == ST_LOAD) && r_use_dp),
    .i_incr      (w_xfer && r_use_dp),
    .i_inval     (w_xfer && r_use_dp && i_bus_error),
    .i_load_addr (r_addr),
    .o_ok        (w_dp_ok),
    .o_next      (w_dp_next)
  );

endmodule

// File: tb/tb_hp48_bus_sequencer.sv
// Directed bench for hp48_bus_sequencer with a small nibble-memory model standing in
// for hp48_bus: ROM nibble = addr[3:0]^A, 16-nibble RAM at 0x80000.
module tb_hp48_bus_sequencer;
  import hp48_bus_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_use_dp;
  logic [19:0] req_address;
  logic [3:0]  req_count;
  logic [63:0] req_wdata;
  logic        req_ready, rsp_valid, rsp_error;
  logic [63:0] rsp_rdata;
  logic [19:0] bus_address;
  logic [3:0]  bus_command, bus_nibble_out, bus_nibble_in;
  logic        bus_error;

  logic [3:0]  ram [16];
  logic [3:0]  mem_nib;

  int n_checks = 0;
  int n_err    = 0;

  int          n_load_pc, n_load_dp, n_x, lat;
  logic [3:0]  x_cmd  [32];
  logic [19:0] x_addr [32];
  logic [3:0]  x_nib  [32];

  always #5 clk = ~clk;

  hp48_bus_sequencer dut (
    .i_strobe         (clk),
    .i_reset          (reset),
    .i_req_valid      (req_valid),
    .o_req_ready      (req_ready),
    .i_req_write      (req_write),
    .i_req_use_dp     (req_use_dp),
    .i_req_address    (req_address),
    .i_req_count      (req_count),
    .i_req_wdata      (req_wdata),
    .o_rsp_valid      (rsp_valid),
    .o_rsp_error      (rsp_error),
    .o_rsp_rdata      (rsp_rdata),
    .o_bus_address    (bus_address),
    .o_bus_command    (bus_command),
    .o_bus_nibble_out (bus_nibble_out),
    .i_bus_nibble_in  (bus_nibble_in),
    .i_bus_error      (bus_error)
  );

  assign mem_nib = (bus_address[19:4] == 16'h8000) ? ram[bus_address[3:0]]
                                                   : (bus_address[3:0] ^ 4'hA);
  assign bus_nibble_in = ((bus_command == BUSCMD_PC_READ) || (bus_command == BUSCMD_DP_READ))
                         ? mem_nib : 4'h0;

  always @(posedge clk) begin
    if ((bus_command == BUSCMD_DP_WRITE) && (bus_address[19:4] == 16'h8000))
      ram[bus_address[3:0]] <= bus_nibble_out;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, then log every bus cycle until rsp_valid (bounded).
  // err_at: XFER index during which bus_error is driven high (-1 = never).
  task automatic do_req(input string tag, input logic w, input logic dp,
                        input logic [19:0] a, input logic [3:0] c,
                        input logic [63:0] wd, input int err_at);
    bit done = 1'b0;
    @(negedge clk);
    check({tag, "_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = w; req_use_dp = dp;
    req_address = a; req_count = c; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n_load_pc = 0; n_load_dp = 0; n_x = 0; lat = 0;
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge clk);
      bus_error = 1'b0;
      if (bus_command == BUSCMD_LOAD_PC) n_load_pc++;
      else if (bus_command == BUSCMD_LOAD_DP) n_load_dp++;
      else if (bus_command != BUSCMD_NOP && n_x < 32) begin
        x_cmd[n_x] = bus_command; x_addr[n_x] = bus_address; x_nib[n_x] = bus_nibble_out;
        if (n_x == err_at) bus_error = 1'b1;
        n_x++;
      end
      if (rsp_valid) begin
        lat  = k;
        done = 1'b1;
      end
    end
    bus_error = 1'b0;
    check({tag, "_rsp_seen"}, 64'(done), 64'd1);
  endtask

  initial begin
    bit ok;
    int pulses;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_use_dp = 1'b0;
    req_address = '0; req_count = '0; req_wdata = '0; bus_error = 1'b0;
    for (int i = 0; i < 16; i++) ram[i] = 4'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_error", 64'(rsp_error), 64'd0);
    check("rst_rdata", rsp_rdata, 64'd0);
    check("rst_cmd", 64'(bus_command), 64'(BUSCMD_NOP));
    check("rst_addr", 64'(bus_address), 64'd0);
    check("rst_nib_out", 64'(bus_nibble_out), 64'd0);

    // Cold read: LOAD_PC then 5 reads, rsp on cycle 7.
    do_req("rd0", 1'b0, 1'b0, 20'h00000, 4'd4, 64'd0, -1);
    check("rd0_load_pc", 64'(n_load_pc), 64'd1);
    check("rd0_load_dp", 64'(n_load_dp), 64'd0);
    check("rd0_nx", 64'(n_x), 64'd5);
    check("rd0_cmd", 64'(x_cmd[0]), 64'(BUSCMD_PC_READ));
    check("rd0_addr0", 64'(x_addr[0]), 64'h00000);
    check("rd0_addr4", 64'(x_addr[4]), 64'h00004);
    check("rd0_lat", 64'(lat), 64'd7);
    check("rd0_rdata", rsp_rdata, 64'h00000000000E98BA);
    check("rd0_err", 64'(rsp_error), 64'd0);
    @(negedge clk);
    check("rd0_pulse_end", 64'(rsp_valid), 64'd0);
    check("rd0_ready_again", 64'(req_ready), 64'd1);

    // Contiguous PC read: pointer hit, no LOAD.
    do_req("rd1", 1'b0, 1'b0, 20'h00005, 4'd0, 64'd0, -1);
    check("rd1_loads", 64'(n_load_pc + n_load_dp), 64'd0);
    check("rd1_addr", 64'(x_addr[0]), 64'h00005);
    check("rd1_lat", 64'(lat), 64'd2);
    check("rd1_rdata", rsp_rdata, 64'h000000000000000F);

    // Write with use_dp=0 still goes through DP and leaves PC tracking alone.
    do_req("wpc", 1'b1, 1'b0, 20'h80000, 4'd0, 64'h3, -1);
    check("wpc_load_dp", 64'(n_load_dp), 64'd1);
    check("wpc_load_pc", 64'(n_load_pc), 64'd0);
    check("wpc_cmd", 64'(x_cmd[0]), 64'(BUSCMD_DP_WRITE));
    check("wpc_nib", 64'(x_nib[0]), 64'h3);
    check("wpc_lat", 64'(lat), 64'd3);
    do_req("rd2", 1'b0, 1'b0, 20'h00006, 4'd0, 64'd0, -1);
    check("rd2_loads", 64'(n_load_pc + n_load_dp), 64'd0);
    check("rd2_rdata", rsp_rdata, 64'h000000000000000C);

    // Full 16-nibble write then read back.
    do_req("w16", 1'b1, 1'b1, 20'h80000, 4'd15, 64'hFEDCBA9876543210, -1);
    check("w16_load_dp", 64'(n_load_dp), 64'd1);
    check("w16_nx", 64'(n_x), 64'd16);
    ok = 1'b1;
    for (int i = 0; i < 16; i++)
      if (x_nib[i] !== 4'(i) || x_cmd[i] !== BUSCMD_DP_WRITE || x_addr[i] !== 20'h80000 + 20'(i))
        ok = 1'b0;
    check("w16_seq", 64'(ok), 64'd1);
    check("w16_lat", 64'(lat), 64'd18);
    do_req("r16", 1'b0, 1'b1, 20'h80000, 4'd15, 64'd0, -1);
    check("r16_load_dp", 64'(n_load_dp), 64'd1);
    check("r16_cmd", 64'(x_cmd[0]), 64'(BUSCMD_DP_READ));
    check("r16_rdata", rsp_rdata, 64'hFEDCBA9876543210);

    // Address wrap at the top of the 20-bit space.
    do_req("wrap", 1'b0, 1'b1, 20'hFFFFE, 4'd3, 64'd0, -1);
    check("wrap_load_dp", 64'(n_load_dp), 64'd1);
    check("wrap_load_pc", 64'(n_load_pc), 64'd0);
    check("wrap_a0", 64'(x_addr[0]), 64'hFFFFE);
    check("wrap_a1", 64'(x_addr[1]), 64'hFFFFF);
    check("wrap_a2", 64'(x_addr[2]), 64'h00000);
    check("wrap_a3", 64'(x_addr[3]), 64'h00001);
    check("wrap_rdata", rsp_rdata, 64'h000000000000BA54);
    do_req("wrap_hit", 1'b0, 1'b1, 20'h00002, 4'd0, 64'd0, -1);
    check("wrap_hit_loads", 64'(n_load_pc + n_load_dp), 64'd0);
    check("wrap_hit_rdata", rsp_rdata, 64'h0000000000000008);

    // bus_error on the 2nd XFER cycle of an 8-nibble read.
    do_req("err", 1'b0, 1'b0, 20'h00100, 4'd7, 64'd0, 1);
    check("err_nx", 64'(n_x), 64'd2);
    check("err_flag", 64'(rsp_error), 64'd1);
    check("err_lat", 64'(lat), 64'd4);
    check("err_rdata0", 64'(rsp_rdata[3:0]), 64'hA);
    do_req("post_err", 1'b0, 1'b0, 20'h00102, 4'd0, 64'd0, -1);
    check("post_err_load", 64'(n_load_pc), 64'd1);
    check("post_err_flag", 64'(rsp_error), 64'd0);
    check("post_err_rdata", rsp_rdata, 64'h0000000000000008);

    // Reset in the middle of a transfer.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_use_dp = 1'b0;
    req_address = 20'h00200; req_count = 4'd7;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_cmd", 64'(bus_command), 64'(BUSCMD_PC_READ));
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_cmd", 64'(bus_command), 64'(BUSCMD_NOP));
    check("rst_mid_rsp", 64'(rsp_valid), 64'd0);
    reset = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    check("rst_no_pulse", 64'(pulses), 64'd0);
    do_req("post_rst_pc", 1'b0, 1'b0, 20'h00202, 4'd0, 64'd0, -1);
    check("post_rst_pc_load", 64'(n_load_pc), 64'd1);
    do_req("post_rst_dp", 1'b0, 1'b1, 20'h00003, 4'd0, 64'd0, -1);
    check("post_rst_dp_load", 64'(n_load_dp), 64'd1);
    check("post_rst_dp_rdata", rsp_rdata, 64'h0000000000000009);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
